// File: rtl/scalar_fetch_sequencer.sv
// scalar_fetch_sequencer
//   Sequences scalar operand fetches for the iteration engine. Iteration 0
//   reads the initial vector from ROM; later iterations read the ping-pong
//   RAM buffers once the update stage pulses NEXT_ITER. Returned words are
//   captured into a 2-entry queue and presented on a valid/ready port.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   START, VEC_LEN,
//   ITER_COUNT               run request; lengths sampled on START (0 -> 1)
//   NEXT_ITER                next ping-pong buffer is written
//   ABORT                    (FETCH_ABORT_EN only) return to IDLE at once
//   RD_ADDR, ROM_RD_EN,
//   BUF_RD_EN, BUF_SEL       read request to ROM / RAM buffers
//   INITIAL_ROM_READ_FLAG    read-flags mux select (1 = ROM, 0 = buffer)
//   SCALAR_IN                mux output, valid the cycle after a strobe
//   SCALAR_DATA/VALID/LAST,
//   SCALAR_READY             downstream handshake (queue head)
//   ITER_IDX, BUSY, DONE     status
//
// Optional feature macro: FETCH_ABORT_EN (adds the ABORT input).
module scalar_fetch_sequencer #(
  parameter int BIT_WIDTH  = 32,
  parameter int EXTRA_BIT  = 2,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           START,
  input  logic [ADDR_WIDTH:0]            VEC_LEN,
  input  logic [15:0]                    ITER_COUNT,
  input  logic                           NEXT_ITER,
`ifdef FETCH_ABORT_EN
  input  logic                           ABORT,
`endif
  output logic [ADDR_WIDTH-1:0]          RD_ADDR,
  output logic                           ROM_RD_EN,
  output logic                           BUF_RD_EN,
  output logic                           BUF_SEL,
  output logic                           INITIAL_ROM_READ_FLAG,
  input  logic [BIT_WIDTH+EXTRA_BIT-1:0] SCALAR_IN,
  output logic [BIT_WIDTH+EXTRA_BIT-1:0] SCALAR_DATA,
  output logic                           SCALAR_VALID,
  output logic                           SCALAR_LAST,
  input  logic                           SCALAR_READY,
  output logic [15:0]                    ITER_IDX,
  output logic                           BUSY,
  output logic                           DONE
);
  localparam int DW = BIT_WIDTH + EXTRA_BIT;
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WAIT_NEXT} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         vec_len_q, vec_len_d;
  logic [15:0]           iter_count_q, iter_count_d;
  logic [15:0]           iter_idx_q, iter_idx_d;
  logic [CW-1:0]         word_cnt_q, word_cnt_d;
  logic                  buf_sel_q, buf_sel_d;
  logic                  rom_flag_q, rom_flag_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  done_q, done_d;
  logic [1:0]            count_q, count_d;
  logic [DW-1:0]         q0_data_q, q0_data_d, q1_data_q, q1_data_d;
  logic                  q0_last_q, q0_last_d, q1_last_q, q1_last_d;

  logic                  pop;
  logic                  issue;
  logic                  abort_req;
  logic [1:0]            cnt_after_pop;
  logic [2:0]            occupancy;

`ifdef FETCH_ABORT_EN
  assign abort_req = ABORT;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    vec_len_d       = vec_len_q;
    iter_count_d    = iter_count_q;
    iter_idx_d      = iter_idx_q;
    word_cnt_d      = word_cnt_q;
    buf_sel_d       = buf_sel_q;
    rom_flag_d      = rom_flag_q;
    rd_addr_d       = rd_addr_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    done_d          = 1'b0;
    q0_data_d       = q0_data_q;
    q0_last_d       = q0_last_q;
    q1_data_d       = q1_data_q;
    q1_last_d       = q1_last_q;
    issue           = 1'b0;

    pop           = (count_q != 2'd0) && SCALAR_READY;
    cnt_after_pop = count_q - {1'b0, pop};
    // Words already buffered or on their way, net of this cycle's pop.
    occupancy     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    // Queue: pop shifts the tail forward, the returning word lands behind
    // whatever survives the pop.
    if (pop) begin
      q0_data_d = q1_data_q;
      q0_last_d = q1_last_q;
    end
    if (inflight_q) begin
      if (cnt_after_pop == 2'd0) begin
        q0_data_d = SCALAR_IN;
        q0_last_d = inflight_last_q;
      end else begin
        q1_data_d = SCALAR_IN;
        q1_last_d = inflight_last_q;
      end
      count_d = cnt_after_pop + 2'd1;
    end else begin
      count_d = cnt_after_pop;
    end

    if (abort_req) begin
      state_d    = IDLE;
      count_d    = 2'd0;
      rom_flag_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            vec_len_d    = (VEC_LEN == '0) ? CW'(1) : VEC_LEN;
            iter_count_d = (ITER_COUNT == 16'd0) ? 16'd1 : ITER_COUNT;
            iter_idx_d   = 16'd0;
            word_cnt_d   = '0;
            buf_sel_d    = 1'b0;
            rom_flag_d   = 1'b1;
            state_d      = FETCH;
          end
        end
        FETCH: begin
          if (occupancy < 3'd2) begin
            issue      = 1'b1;
            rd_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
            word_cnt_d = word_cnt_q + CW'(1);
            inflight_d = 1'b1;
            if (word_cnt_q == vec_len_q - CW'(1)) begin
              inflight_last_d = 1'b1;
              state_d         = DRAIN;
            end
          end
        end
        DRAIN: begin
          // count_d == 0 means the final word was handed over this cycle.
          if (count_d == 2'd0 && !inflight_q) begin
            if (iter_idx_q == iter_count_q - 16'd1) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              iter_idx_d = iter_idx_q + 16'd1;
              word_cnt_d = '0;
              // Leaving the ROM pass: buffer 0 is read next, so no toggle.
              if (iter_idx_q == 16'd0) begin
                rom_flag_d = 1'b0;
              end else begin
                buf_sel_d = ~buf_sel_q;
              end
              state_d = WAIT_NEXT;
            end
          end
        end
        WAIT_NEXT: begin
          if (NEXT_ITER) begin
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= IDLE;
      vec_len_q       <= CW'(1);
      iter_count_q    <= 16'd1;
      iter_idx_q      <= 16'd0;
      word_cnt_q      <= '0;
      buf_sel_q       <= 1'b0;
      rom_flag_q      <= 1'b1;
      rd_addr_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      vec_len_q       <= vec_len_d;
      iter_count_q    <= iter_count_d;
      iter_idx_q      <= iter_idx_d;
      word_cnt_q      <= word_cnt_d;
      buf_sel_q       <= buf_sel_d;
      rom_flag_q      <= rom_flag_d;
      rd_addr_q       <= rd_addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
      count_q         <= count_d;
    end
  end

  // Queue payload is qualified by count_q, so it needs no reset.
  always_ff @(posedge CLK) begin
    q0_data_q <= q0_data_d;
    q0_last_q <= q0_last_d;
    q1_data_q <= q1_data_d;
    q1_last_q <= q1_last_d;
  end

  assign RD_ADDR               = rd_addr_d;
  assign ROM_RD_EN             = issue & rom_flag_q;
  assign BUF_RD_EN             = issue & ~rom_flag_q;
  assign BUF_SEL               = buf_sel_q;
  assign INITIAL_ROM_READ_FLAG = rom_flag_q;
  assign SCALAR_VALID          = (count_q != 2'd0);
  assign SCALAR_DATA           = SCALAR_VALID ? q0_data_q : '0;
  assign SCALAR_LAST           = SCALAR_VALID & q0_last_q;
  assign ITER_IDX              = iter_idx_q;
  assign BUSY                  = (state_q != IDLE);
  assign DONE                  = done_q;

endmodule

// File: tb/tb_scalar_fetch_sequencer.sv
// Testbench for scalar_fetch_sequencer: directed runs checked against a
// scoreboard of expected reads and delivered words, plus literal timing
// expectations for start-up, handoff and reset.
module tb_scalar_fetch_sequencer;
  localparam int AW = 8;
  localparam int DW = 34;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW:0]   vec_len;
  logic [15:0]   iter_count;
  logic          next_iter;
  logic          abort;
  logic [AW-1:0] rd_addr;
  logic          rom_en;
  logic          buf_en;
  logic          buf_sel;
  logic          flag;
  logic [DW-1:0] scalar_in;
  logic [DW-1:0] sdata;
  logic          svalid;
  logic          slast;
  logic          sready;
  logic [15:0]   iter_idx;
  logic          busy;
  logic          done;

  scalar_fetch_sequencer #(.BIT_WIDTH(32), .EXTRA_BIT(2), .ADDR_WIDTH(AW)) dut (
    .CLK(clk), .RST(rst), .START(start), .VEC_LEN(vec_len), .ITER_COUNT(iter_count),
    .NEXT_ITER(next_iter),
`ifdef FETCH_ABORT_EN
    .ABORT(abort),
`endif
    .RD_ADDR(rd_addr), .ROM_RD_EN(rom_en), .BUF_RD_EN(buf_en), .BUF_SEL(buf_sel),
    .INITIAL_ROM_READ_FLAG(flag), .SCALAR_IN(scalar_in), .SCALAR_DATA(sdata),
    .SCALAR_VALID(svalid), .SCALAR_LAST(slast), .SCALAR_READY(sready),
    .ITER_IDX(iter_idx), .BUSY(busy), .DONE(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory contents: src 0 = ROM, 1 = buffer 0, 2 = buffer 1.
  function automatic logic [DW-1:0] mem_word(input int src, input int addr);
    logic [31:0] a;
    a = 32'(addr);
    case (src)
      0:       return {2'b01, 32'hA500_0000 | a};
      1:       return {2'b10, 32'hB600_0000 | a};
      default: return {2'b11, 32'hC700_0000 | a};
    endcase
  endfunction

  // ROM / buffer responder: one-cycle read latency, garbage when idle.
  logic          s_rom, s_buf, s_sel;
  logic [AW-1:0] s_addr;
  always @(negedge clk) begin
    s_rom  = rom_en;
    s_buf  = buf_en;
    s_sel  = buf_sel;
    s_addr = rd_addr;
  end
  always @(posedge clk) begin
    #1;
    if (s_rom)      scalar_in = mem_word(0, int'(s_addr));
    else if (s_buf) scalar_in = mem_word(s_sel ? 2 : 1, int'(s_addr));
    else            scalar_in = 34'h2_5555_5555;
  end

  // Scoreboard of a run: every word of every iteration, in order.
  typedef struct {
    int iter;
    int src;
    int addr;
    bit last;
  } ent_t;

  ent_t rd_q[$];
  ent_t exp_q[$];
  bit   model_en = 1'b0;
  int   issued, popped, iters_done, nexts_sent, total_iters;
  bit   flag_exp, done_due, done_seen;

  task automatic arm(input int l, input int n);
    int le, ne;
    ent_t e;
    le = (l == 0) ? 1 : l;
    ne = (n == 0) ? 1 : n;
    rd_q.delete();
    exp_q.delete();
    for (int it = 0; it < ne; it++) begin
      for (int a = 0; a < le; a++) begin
        e.iter = it;
        e.src  = (it == 0) ? 0 : ((it % 2 == 1) ? 1 : 2);
        e.addr = a;
        e.last = (a == le - 1);
        rd_q.push_back(e);
        exp_q.push_back(e);
      end
    end
    issued = 0; popped = 0; iters_done = 0; nexts_sent = 0;
    total_iters = ne; flag_exp = 1'b1; done_due = 1'b0; done_seen = 1'b0;
    model_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (model_en) begin
      ent_t e;
      int   got_src;
      bit   hs;
      chk("done_pulse", 64'(done), 64'(done_due));
      if (done_due) begin
        chk("busy_at_done", 64'(busy), 64'd0);
        done_seen = 1'b1;
      end
      done_due = 1'b0;
      chk("rom_flag", 64'(flag), 64'(flag_exp));
      chk("rd_en_excl", 64'(rom_en & buf_en), 64'd0);
      if (rom_en || buf_en) begin
        issued++;
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", 64'(rom_en | buf_en), 64'd0);
        end else begin
          e = rd_q.pop_front();
          got_src = rom_en ? 0 : (buf_sel ? 2 : 1);
          chk("rd_addr", 64'(rd_addr), 64'(e.addr));
          chk("rd_src", 64'(got_src), 64'(e.src));
          chk("rd_before_next", 64'(nexts_sent >= e.iter), 64'd1);
        end
      end
      hs = svalid && sready;
      if (hs) begin
        popped++;
        if (exp_q.size() == 0) begin
          chk("word_unexpected", 64'(hs), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", 64'(sdata), 64'(mem_word(e.src, e.addr)));
          chk("word_last", 64'(slast), 64'(e.last));
          chk("word_iter", 64'(iter_idx), 64'(e.iter));
          if (e.last) begin
            iters_done++;
            if (e.iter == total_iters - 1) done_due = 1'b1;
            else if (e.iter == 0)          flag_exp = 1'b0;
          end
        end
      end
      chk("occupancy", 64'(issued - popped <= 2), 64'd1);
    end
  end

  task automatic start_run(input int l, input int n);
    vec_len    = (AW+1)'(l);
    iter_count = 16'(n);
    start      = 1'b1;
    step();
    start      = 1'b0;
    arm(l, n);
  endtask

  task automatic drive_iters(input int n, input int gap);
    for (int k = 1; k < n; k++) begin
      int w = 0;
      while (iters_done < k && w < 3000) begin
        step();
        w++;
      end
      chk("iter_drained", 64'(iters_done >= k), 64'd1);
      repeat (gap) step();
      next_iter = 1'b1;
      step();
      next_iter  = 1'b0;
      nexts_sent = k;
      @(negedge clk);
      chk("handoff_rd", 64'(buf_en), 64'd1);
      chk("handoff_addr", 64'(rd_addr), 64'd0);
      @(negedge clk);
      @(negedge clk);
      chk("handoff_valid", 64'(svalid), 64'd1);
    end
  endtask

  task automatic wait_done(input int budget);
    int w = 0;
    while (!done_seen && w < budget) begin
      step();
      w++;
    end
    chk("done_seen", 64'(done_seen), 64'd1);
  endtask

  task automatic finish_run();
    repeat (2) step();
    chk("reads_left", 64'(rd_q.size()), 64'd0);
    chk("words_left", 64'(exp_q.size()), 64'd0);
    model_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_rom_en"},  64'(rom_en), 64'd0);
    chk({tag, "_buf_en"},  64'(buf_en), 64'd0);
    chk({tag, "_buf_sel"}, 64'(buf_sel), 64'd0);
    chk({tag, "_flag"},    64'(flag), 64'd1);
    chk({tag, "_valid"},   64'(svalid), 64'd0);
    chk({tag, "_data"},    64'(sdata), 64'd0);
    chk({tag, "_last"},    64'(slast), 64'd0);
    chk({tag, "_iter"},    64'(iter_idx), 64'd0);
    chk({tag, "_busy"},    64'(busy), 64'd0);
    chk({tag, "_done"},    64'(done), 64'd0);
  endtask

  initial begin
    bit pat [4];
    int w;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; start = 1'b0; vec_len = '0; iter_count = '0;
    next_iter = 1'b0; abort = 1'b0; sready = 1'b1;
    step(); step();
    @(negedge clk);
    chk_reset_vals("reset");
    step();
    rst = 1'b0;
    step();

    // Single ROM iteration with literal start-up timing.
    start_run(4, 1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("t1_rom_en", 64'(rom_en), 64'(c >= 1 && c <= 4));
      if (c <= 4) chk("t1_addr", 64'(rd_addr), 64'(c - 1));
      chk("t1_valid", 64'(svalid), 64'(c >= 3 && c <= 6));
      if (c == 6) chk("t1_last", 64'(slast), 64'd1);
      chk("t1_done", 64'(done), 64'(c == 7));
      chk("t1_flag", 64'(flag), 64'd1);
    end
    finish_run();

    // Three iterations: ROM, buffer 0, buffer 1.
    start_run(3, 3);
    drive_iters(3, 5);
    wait_done(200);
    chk("t3_flag_after", 64'(flag), 64'd0);
    finish_run();

    // Backpressure with READY 1,0,0,1.
    start_run(8, 1);
    w = 0;
    while (!done_seen && w < 300) begin
      sready = pat[w % 4];
      step();
      w++;
    end
    sready = 1'b1;
    wait_done(50);
    finish_run();

    // Stray START / NEXT_ITER during FETCH.
    start_run(5, 2);
    step();
    start = 1'b1; vec_len = 9'd2; iter_count = 16'd1;
    step();
    start = 1'b0; next_iter = 1'b1;
    step();
    next_iter = 1'b0; vec_len = 9'd5; iter_count = 16'd2;
    @(negedge clk);
    chk("stray_busy", 64'(busy), 64'd1);
    chk("stray_iter", 64'(iter_idx), 64'd0);
    drive_iters(2, 3);
    wait_done(200);
    finish_run();

    // Boundary lengths.
    start_run(0, 1);
    wait_done(50);
    finish_run();
    start_run(256, 1);
    wait_done(400);
    finish_run();

    // Reset in cycle 2 of a fetch.
    start_run(4, 1);
    step();
    model_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    @(negedge clk);
    chk("midrst_valid2", 64'(svalid), 64'd0);
    chk("midrst_busy2", 64'(busy), 64'd0);

`ifdef FETCH_ABORT_EN
    step();
    start_run(4, 2);
    step();
    model_en = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", 64'(svalid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_flag", 64'(flag), 64'd1);
    chk("abort_rd", 64'(rom_en | buf_en), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    chk("abort_valid2", 64'(svalid), 64'd0);
    chk("abort_done2", 64'(done), 64'd0);
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
